// File: rtl/operand_loader_pkg.sv
// Shared types and default sizing for the operand pair loader and its FIFO.
package operand_loader_pkg;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of W-bit entries; head is read combinationally from storage,
// so a pushed entry is visible the cycle after its push edge (no bypass).
module pair_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/operand_pair_loader.sv
// Assembles an A,B byte stream into operand pairs and queues them for the adder
// stage; flush drops everything buffered, reset also clears storage.
module operand_pair_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [DATA_W-1:0]       a_out,
  output logic [DATA_W-1:0]       b_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             pair_cnt
);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_W-1:0]      a_hold_p0;
  logic [15:0]            pair_cnt_q;
  logic [2*DATA_W-1:0]    head;
  logic                   full;
  logic                   empty;
  logic                   xfer;
  logic                   push;
  logic                   pop;

  // in_ready depends only on state, full and flush, never on out_ready.
  assign in_ready = !rst && !flush && ((state == WAIT_A) || !full);
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && (state == WAIT_B);
  assign pop      = out_valid && out_ready && !flush;

  always_comb begin
    state_nxt = state;
    if (flush)     state_nxt = WAIT_A;
    else if (xfer) state_nxt = (state == WAIT_A) ? WAIT_B : WAIT_A;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_A;
    else     state <= state_nxt;
  end

  // Stage p0: pending operand A waiting for its partner
  always_ff @(posedge clk) begin
    if (rst)                              a_hold_p0 <= '0;
    else if (xfer && (state == WAIT_A))   a_hold_p0 <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) pair_cnt_q <= '0;
    else if (pop)     pair_cnt_q <= pair_cnt_q + 16'd1;
  end

  pair_fifo #(
    .W     (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   ({a_hold_p0, in_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
  assign a_out     = head[2*DATA_W-1:DATA_W];
  assign b_out     = head[DATA_W-1:0];
  assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_operand_pair_loader.sv
// Scoreboard bench: the driver queues expected pairs, a negedge monitor pops and compares.
module tb_operand_pair_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic [15:0] pair_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  operand_pair_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .pair_cnt  (pair_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int waited = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    chk("send_ready_timeout", 32'(waited < 200), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    send(a);
    send(b);
    exp_q.push_back({a, b});
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      tick();
      waited++;
    end
    chk("drain_timeout", 32'(waited < 500), 32'd1);
    tick();
  endtask

  // Monitor: a pop happens at the next edge whenever the head is offered and taken.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", {16'd0, a_out, b_out}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("pair_a", {24'd0, a_out}, {24'd0, e[15:8]});
        chk("pair_b", {24'd0, b_out}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_pair_cnt", {16'd0, pair_cnt}, 32'd0);
    chk("rst_a_out", {24'd0, a_out}, 32'd0);
    chk("rst_b_out", {24'd0, b_out}, 32'd0);
    chk("rst_wait_a_ready", {31'd0, in_ready}, 32'd1);

    // Single pair, visible one cycle after the B edge
    out_ready = 1'b1;
    send_pair(8'h12, 8'h34);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_a", {24'd0, a_out}, 32'h12);
    chk("first_b", {24'd0, b_out}, 32'h34);
    tick();
    chk("first_cnt", {16'd0, pair_cnt}, 32'd1);

    // Fill to full, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(8'(2*i+1), 8'(2*i+2));
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_a_head", {24'd0, a_out}, 32'h01);
    send(8'h09);
    chk("full_wait_b_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("no_comb_ready_path", {31'd0, in_ready}, 32'd0);
    tick();
    chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
    chk("level_after_pop", {29'd0, level}, 32'd3);
    drain();
    chk("drained_level", {29'd0, level}, 32'd0);
    send(8'h0A);
    exp_q.push_back(16'h090A);
    drain();
    chk("cnt_after_fill", {16'd0, pair_cnt}, 32'd6);

    // Push and pop in the same edge at level 2
    out_ready = 1'b0;
    send_pair(8'hA1, 8'hB1);
    send_pair(8'hA2, 8'hB2);
    chk("lvl2", {29'd0, level}, 32'd2);
    send(8'hA3);
    out_ready = 1'b1;
    send(8'hB3);
    exp_q.push_back(16'hA3B3);
    chk("lvl2_pushpop", {29'd0, level}, 32'd2);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 3 != 0);
      send_pair(8'(8'h20 + i), 8'(8'h80 + i));
    end
    out_ready = 1'b1;
    drain();
    chk("wrap_level", {29'd0, level}, 32'd0);
    chk("wrap_cnt", {16'd0, pair_cnt}, 32'd29);

    // Flush with a pending A and one queued pair
    out_ready = 1'b0;
    send_pair(8'hC1, 8'hC2);
    send(8'hAA);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    #1;
    chk("flush_level", {29'd0, level}, 32'd0);
    chk("flush_cnt", {16'd0, pair_cnt}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send_pair(8'h55, 8'h66);
    drain();
    chk("flush_next_cnt", {16'd0, pair_cnt}, 32'd1);

    // Counter wrap: preload the counter to its maximum, then one more pop
    force dut.pair_cnt_q = 16'hFFFF;
    #1;
    release dut.pair_cnt_q;
    #1;
    chk("cnt_preload", {16'd0, pair_cnt}, 32'hFFFF);
    send_pair(8'h77, 8'h88);
    drain();
    chk("cnt_wrap", {16'd0, pair_cnt}, 32'd0);

    // Reset in WAIT_B with two pairs queued
    out_ready = 1'b0;
    send_pair(8'hD1, 8'hD2);
    send_pair(8'hE1, 8'hE2);
    send(8'h33);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_level", {29'd0, level}, 32'd0);
    chk("midrst_cnt", {16'd0, pair_cnt}, 32'd0);
    chk("midrst_a_out", {24'd0, a_out}, 32'd0);
    chk("midrst_b_out", {24'd0, b_out}, 32'd0);
    out_ready = 1'b1;
    send_pair(8'h01, 8'h02);
    drain();
    chk("midrst_cnt_after", {16'd0, pair_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_pair_loader.md
OPERAND_PAIR_LOADER -- requirements
Module: operand_pair_loader

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits.
REQ-002 Parameter DEPTH, default 4, pair-FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  operand byte stream; first byte is A, second is B.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts in_data; transfer = in_valid & in_ready.
REQ-008 flush  input  1  synchronous discard of all buffered data.
REQ-009 a_out  output  DATA_W  head-pair operand A, feeding the adder stage.
REQ-010 b_out  output  DATA_W  head-pair operand B, feeding the adder stage.
REQ-011 out_valid  output  1  head pair is valid.
REQ-012 out_ready  input  1  adder stage consumes the pair; pop = out_valid & out_ready.
REQ-013 level  output  $clog2(DEPTH)+1  number of pairs currently buffered.
REQ-014 pair_cnt  output  16  count of pairs popped since reset or flush.

Function
REQ-015 The assembler FSM SHALL have exactly two states, WAIT_A and WAIT_B, with reset state WAIT_A.
REQ-016 In WAIT_A, a transfer SHALL store in_data into internal a_hold and move to WAIT_B.
REQ-017 In WAIT_B, a transfer SHALL push {a_hold, in_data} into the FIFO in the same edge and move to WAIT_A.
REQ-018 in_ready SHALL be 1 in WAIT_A, and in WAIT_B SHALL equal !full; it SHALL have no combinational path from out_ready.
REQ-019 A pushed pair SHALL appear at out_valid/a_out/b_out exactly one cycle after the B transfer edge; there is no bypass.
REQ-020 out_valid SHALL equal !empty; a_out/b_out SHALL hold the head entry and stay stable while out_valid & !out_ready.
REQ-021 Simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-022 When full, push is impossible (in_ready=0 in WAIT_B); a pop in that cycle raises in_ready on the next cycle.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-024 pair_cnt SHALL increment by 1 per pop and wrap from 0xFFFF to 0x0000.
REQ-025 flush=1 SHALL empty the FIFO, zero level and pair_cnt, discard a_hold, and force WAIT_A on the next edge.
REQ-026 flush SHALL override any push or pop in the same cycle; in_ready SHALL be 0 while flush=1.

Reset
REQ-027 While rst=1: in_ready=0; after the edge: out_valid=0, level=0, pair_cnt=0, a_out=b_out=0, state WAIT_A.
REQ-028 All FIFO storage and a_hold SHALL be cleared to 0 by reset, but not by flush.
REQ-029 rst asserted mid-pair SHALL discard the pending A; the first byte after reset is A.
REQ-030 rst SHALL take priority over flush and all transfers.

Structure
REQ-031 Package operand_loader_pkg SHALL hold the FSM state enum (WAIT_A, WAIT_B) and default constants DATA_W=8, DEPTH=4.
REQ-032 The storage SHALL be one sub-module, pair_fifo: a synchronous FIFO, 2*DATA_W wide, with push, pop, clr, full, empty, and level signals.
REQ-033 Total RTL is expected to be 150-300 lines.

Verification
REQ-034 Reset, then stream 0x12, 0x34 with out_ready=1 -> a_out=0x12, b_out=0x34, out_valid=1 one cycle after the 0x34 transfer, pair_cnt=1 after the pop.
REQ-035 out_ready=0, push 4 pairs (0x01..0x08) -> level=4, in_ready=0 in WAIT_B; set out_ready=1 -> pairs (01,02), (03,04), (05,06), (07,08) pop in order, level returns to 0.
REQ-036 FIFO at level 2, push and pop in the same cycle -> level stays 2, order intact; run 20 pairs -> pointers wrap with no loss.
REQ-037 Send A=0xAA, then assert flush -> level=0, pair_cnt=0, state WAIT_A; next bytes 0x55, 0x66 -> pair (0x55, 0x66).
REQ-038 pair_cnt preloaded to 0xFFFF via 65535 pops, one more pop -> pair_cnt=0x0000.
REQ-039 rst asserted while in WAIT_B with 2 pairs queued -> all outputs at reset values; next bytes 0x01, 0x02 -> pair (0x01, 0x02).
